// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALUOp encodings, count constants and leading-zero helper shared by the arbiter slice
package alu_arbiter_pkg;
   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_SUB     = 3'b001,
      OP_OR      = 3'b010,
      OP_XOR     = 3'b011,
      OP_NOR     = 3'b100,
      OP_CLO     = 3'b101,
      OP_CLZ     = 3'b110,
      OP_ILLEGAL = 3'b111
   } alu_op_e;
   localparam logic [31:0] ALL_BITS = 32'h20;
   // Scans upward so the last hit is the highest set bit; no set bit leaves ALL_BITS.
   function automatic logic [31:0] lead_zeros(input logic [31:0] v);
      lead_zeros = ALL_BITS;
      for (int i = 0; i < 32; i++)
         if (v[i]) lead_zeros = 32'(31 - i);
   endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle between two requesters, one consumer and the arbiter
//   req0_*/req1_* : valid, ready, operands a/b, 3-bit ALUOp
//   rsp_*         : valid, ready, id, result, err
//   gnt_cnt0/1    : per-requester accepted-op counters (CNT_W bits, saturating)
//   master = requester/consumer side, slave = arbiter side
interface alu_arbiter_if #(parameter int CNT_W = 16);
   logic             req0_valid, req0_ready;
   logic [31:0]      req0_a, req0_b;
   logic [2:0]       req0_op;
   logic             req1_valid, req1_ready;
   logic [31:0]      req1_a, req1_b;
   logic [2:0]       req1_op;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0]      rsp_result;
   logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_result, gnt_cnt0, gnt_cnt1
   );
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_result, gnt_cnt0, gnt_cnt1
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 32-bit alu
//   a_i, b_i : operands (b_i ignored for CLO/CLZ)
//   op_i     : ALUOp
//   result_o : outcome, 0 for the illegal op
//   err_o    : op was the illegal encoding
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   output logic [31:0] result_o,
   output logic        err_o
);
   always_comb begin
      err_o    = op_i == OP_ILLEGAL;
      result_o = op_i == OP_ADD ? a_i + b_i :
                 op_i == OP_SUB ? a_i - b_i :
                 op_i == OP_OR  ? a_i | b_i :
                 op_i == OP_XOR ? a_i ^ b_i :
                 op_i == OP_NOR ? ~(a_i | b_i) :
                 op_i == OP_CLO ? lead_zeros(~a_i) :
                 op_i == OP_CLZ ? lead_zeros(a_i) : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters with round-robin/fixed grant and a registered response
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_arbiter_if slave (request ports, response port, grant counters)
//   RR_EN : 1 = round-robin, 0 = req0 always wins a tie
//   CNT_W : grant counter width
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus
);
   logic             free, win1, rdy0, rdy1, acc;
   logic             ptr_q, ptr_d;
   logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic [31:0]      alu_a, alu_b, alu_result;
   logic [2:0]       alu_op;
   logic             alu_err;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   alu_arbiter_alu u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .result_o (alu_result),
      .err_o    (alu_err)
   );

   // ptr_q=1 hands a tie to req1; it only moves on an accept, so an idle side keeps its turn.
   always_comb begin
      free         = !rsp_valid_q || bus.rsp_ready;
      win1         = (bus.req0_valid && bus.req1_valid) ? (RR_EN && ptr_q) : bus.req1_valid;
      rdy0         = free && bus.req0_valid && !win1;
      rdy1         = free && bus.req1_valid && win1;
      acc          = rdy0 || rdy1;
      alu_a        = win1 ? bus.req1_a : bus.req0_a;
      alu_b        = win1 ? bus.req1_b : bus.req0_b;
      alu_op       = win1 ? bus.req1_op : bus.req0_op;
      rsp_valid_d  = acc || (rsp_valid_q && !bus.rsp_ready);
      rsp_id_d     = acc ? win1 : rsp_id_q;
      rsp_err_d    = acc ? alu_err : rsp_err_q;
      rsp_result_d = acc ? alu_result : rsp_result_q;
      ptr_d        = acc ? !win1 : ptr_q;
      cnt0_d       = (rdy0 && !(&cnt0_q)) ? cnt0_q + 1'b1 : cnt0_q;
      cnt1_d       = (rdy1 && !(&cnt1_q)) ? cnt1_q + 1'b1 : cnt1_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_result_q <= '0;
         ptr_q        <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_err_q    <= rsp_err_d;
         rsp_result_q <= rsp_result_d;
         ptr_q        <= ptr_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.gnt_cnt0   = cnt0_q;
   assign bus.gnt_cnt1   = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter against a transaction-level model
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;
   logic clk = 1'b0, reset = 1'b0;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.CNT_W(16)) bus();
   alu_arbiter_if #(.CNT_W(3))  fif();
   alu_arbiter #(.RR_EN(1'b1), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   alu_arbiter #(.RR_EN(1'b0), .CNT_W(3))  dut_fp (.clk(clk), .reset(reset), .bus(fif));

   assign fif.req0_valid = bus.req0_valid;
   assign fif.req0_a     = bus.req0_a;
   assign fif.req0_b     = bus.req0_b;
   assign fif.req0_op    = bus.req0_op;
   assign fif.req1_valid = bus.req1_valid;
   assign fif.req1_a     = bus.req1_a;
   assign fif.req1_b     = bus.req1_b;
   assign fif.req1_op    = bus.req1_op;
   assign fif.rsp_ready  = bus.rsp_ready;

   // Model of the round-robin DUT: held response, counters, and whose turn a tie is.
   bit          m_valid, m_id, m_err, turn;
   logic [31:0] m_res;
   int          m_cnt0, m_cnt1;

   function automatic logic [32:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      int n = 0;
      case (op)
         3'd0: return {1'b0, a + b};
         3'd1: return {1'b0, a - b};
         3'd2: return {1'b0, a | b};
         3'd3: return {1'b0, a ^ b};
         3'd4: return {1'b0, ~(a | b)};
         3'd5: begin while (n < 32 && a[31-n]) n++; return {1'b0, 32'(n)}; end
         3'd6: begin while (n < 32 && !a[31-n]) n++; return {1'b0, 32'(n)}; end
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic int winner();
      if (bus.req0_valid && bus.req1_valid) return int'(turn);
      if (bus.req0_valid) return 0;
      if (bus.req1_valid) return 1;
      return -1;
   endfunction

   function automatic logic [1:0] exp_rdy();
      bit fr = !m_valid || bus.rsp_ready;
      int w = winner();
      return {fr && w == 0, fr && w == 1};
   endfunction

   function automatic logic [66:0] m_vec();
      return {m_valid, m_id, m_err, m_res, 16'(m_cnt0), 16'(m_cnt1)};
   endfunction

   function automatic logic [66:0] d_vec();
      return {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.gnt_cnt0, bus.gnt_cnt1};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_err = 0; m_res = 0; m_cnt0 = 0; m_cnt1 = 0; turn = 0;
   endtask

   // Advance one clock: decide acceptance from the model before the edge, apply it after.
   task automatic tick();
      int w = winner();
      bit acc = (!m_valid || bus.rsp_ready) && w >= 0;
      bit rr = bus.rsp_ready;
      logic [32:0] r = (w == 1) ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b)
                                : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
      @(posedge clk);
      if (!reset) model_reset();
      else if (acc) begin
         m_valid = 1; m_id = w[0]; {m_err, m_res} = r; turn = !w[0];
         if (w == 0) m_cnt0 = m_cnt0 < 65535 ? m_cnt0 + 1 : m_cnt0;
         else m_cnt1 = m_cnt1 < 65535 ? m_cnt1 + 1 : m_cnt1;
      end else if (rr) m_valid = 0;
      #1;
   endtask

   task automatic drive(bit v0, logic [2:0] op0, logic [31:0] a0, logic [31:0] b0,
                        bit v1, logic [2:0] op1, logic [31:0] a1, logic [31:0] b1, bit rr);
      bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
      bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
      bus.rsp_ready = rr;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      reset = 1'b0;
      #1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (d_vec() !== 67'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", d_vec()); end
      checks++;
      if ({fif.rsp_valid, fif.gnt_cnt0, fif.gnt_cnt1} !== 7'd0) begin
         errors++; $display("FAIL reset_fp got=%h exp=0", {fif.rsp_valid, fif.gnt_cnt0, fif.gnt_cnt1});
      end
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_idle_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready});
      end
   endtask

   task automatic test_single_add();
      do_reset();
      drive(1, OP_ADD, 5, 3, 0, OP_ADD, 0, 0, 1);
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         errors++; $display("FAIL add_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready});
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.gnt_cnt0} !== {1'b1, 1'b0, 32'd8, 16'd1}) begin
         errors++; $display("FAIL add_rsp got=%h exp=%h",
            {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.gnt_cnt0}, {1'b1, 1'b0, 32'd8, 16'd1});
      end
      drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", bus.rsp_valid); end
   endtask

   task automatic test_round_robin();
      do_reset();
      drive(1, OP_SUB, 10, 3, 1, OP_XOR, 32'hF0F0_0000, 32'h0FF0_0000, 1);
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, {bus.req0_ready, bus.req1_ready},
               (i % 2) ? 2'b01 : 2'b10);
         end
         tick();
         checks++;
         if ({bus.rsp_id, bus.rsp_result} !== {i[0], (i % 2) ? 32'hFF00_0000 : 32'd7}) begin
            errors++; $display("FAIL rr_rsp[%0d] got=%h exp=%h", i, {bus.rsp_id, bus.rsp_result},
               {i[0], (i % 2) ? 32'hFF00_0000 : 32'd7});
         end
      end
      checks++;
      if ({bus.gnt_cnt0, bus.gnt_cnt1} !== {16'd4, 16'd4}) begin
         errors++; $display("FAIL rr_counts got=%h exp=%h", {bus.gnt_cnt0, bus.gnt_cnt1}, {16'd4, 16'd4});
      end
   endtask

   task automatic test_count_ops();
      logic [2:0]  ops [4] = '{OP_CLZ, OP_CLO, OP_CLZ, OP_CLO};
      logic [31:0] as  [4] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF};
      logic [31:0] exs [4] = '{32'd16, 32'd32, 32'd32, 32'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, OP_ADD, 0, 0, 1, ops[i], as[i], $urandom, 1);
         tick();
         checks++;
         if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result} !== {3'b110, exs[i]}) begin
            errors++; $display("FAIL count_op[%0d] got=%h exp=%h", i,
               {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result}, {3'b110, exs[i]});
         end
      end
      for (int i = 0; i < 10; i++) begin
         drive(1, 3'($urandom_range(0, 6)), $urandom >> $urandom_range(0, 31), $urandom,
               0, OP_ADD, 0, 0, 1);
         tick();
         checks++;
         if (d_vec() !== m_vec()) begin
            errors++; $display("FAIL alu_op[%0d] got=%h exp=%h", i, d_vec(), m_vec());
         end
      end
   endtask

   task automatic test_backpressure();
      logic [66:0] snap;
      do_reset();
      drive(1, OP_ADD, 1, 2, 0, OP_ADD, 0, 0, 1);
      tick();
      drive(1, OP_OR, 32'h00FF, 32'hFF00, 1, OP_NOR, 32'h1234_0000, 32'h0000_5678, 0);
      snap = d_vec();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {bus.req0_ready, bus.req1_ready});
         end
         tick();
         checks++;
         if (d_vec() !== snap || snap[66] !== 1'b1) begin
            errors++; $display("FAIL bp_stable[%0d] got=%h exp=%h", i, d_vec(), snap);
         end
      end
      bus.rsp_ready = 1;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
         errors++; $display("FAIL bp_release_ready got=%b exp=01", {bus.req0_ready, bus.req1_ready});
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {2'b11, 32'hEDCB_A987} || d_vec() !== m_vec()) begin
         errors++; $display("FAIL bp_release_rsp got=%h exp=%h", d_vec(), m_vec());
      end
   endtask

   task automatic test_illegal_reset();
      do_reset();
      drive(1, OP_ILLEGAL, 123, 456, 0, OP_ADD, 0, 0, 0);
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_result} !== {2'b11, 32'd0}) begin
         errors++; $display("FAIL illegal got=%h exp=%h", {bus.rsp_valid, bus.rsp_err, bus.rsp_result},
            {2'b11, 32'd0});
      end
      drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0);
      reset = 1'b0;
      #1;
      checks++;
      if (d_vec() !== 67'd0) begin errors++; $display("FAIL async_reset got=%h exp=0", d_vec()); end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_fixed_priority();
      do_reset();
      drive(1, OP_ADD, 1, 1, 1, OP_SUB, 5, 1, 1);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({fif.req0_ready, fif.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL fp_ready[%0d] got=%b exp=10", i, {fif.req0_ready, fif.req1_ready});
         end
         tick();
      end
      checks++;
      if ({fif.gnt_cnt0, fif.gnt_cnt1} !== {3'd4, 3'd0}) begin
         errors++; $display("FAIL fp_counts got=%h exp=%h", {fif.gnt_cnt0, fif.gnt_cnt1}, {3'd4, 3'd0});
      end
      repeat (6) tick();
      checks++;
      if ({fif.gnt_cnt0, fif.gnt_cnt1} !== {3'd7, 3'd0}) begin
         errors++; $display("FAIL fp_saturate got=%h exp=%h", {fif.gnt_cnt0, fif.gnt_cnt1}, {3'd7, 3'd0});
      end
   endtask

   task automatic test_random();
      bit v0 = 0, v1 = 0, rr, held0, held1;
      logic [2:0] op0, op1;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0] er;
      do_reset();
      er = 2'b00;
      for (int i = 0; i < 300; i++) begin
         held0 = v0 && !er[1];
         held1 = v1 && !er[0];
         if (!held0) begin
            v0 = $urandom_range(0, 3) != 0; op0 = 3'($urandom_range(0, 7));
            a0 = $urandom >> $urandom_range(0, 32); b0 = $urandom;
            if ($urandom_range(0, 1)) a0 = ~a0;
         end else if ($urandom_range(0, 7) == 0) v0 = 0;
         if (!held1) begin
            v1 = $urandom_range(0, 3) != 0; op1 = 3'($urandom_range(0, 7));
            a1 = $urandom >> $urandom_range(0, 32); b1 = $urandom;
            if ($urandom_range(0, 1)) a1 = ~a1;
         end else if ($urandom_range(0, 7) == 0) v1 = 0;
         rr = $urandom_range(0, 3) != 0;
         drive(v0, op0, a0, b0, v1, op1, a1, b1, rr);
         #1;
         er = exp_rdy();
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== er) begin
            errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, {bus.req0_ready, bus.req1_ready}, er);
         end
         tick();
         checks++;
         if (d_vec() !== m_vec()) begin
            errors++; $display("FAIL rand_rsp[%0d] got=%h exp=%h", i, d_vec(), m_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_count_ops();
      test_backpressure();
      test_illegal_reset();
      test_fixed_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the combinational 32-bit alu between two requesters, for example the EX-stage path and a secondary unit such as a branch-compare or debug port. It arbitrates round-robin with a valid/ready handshake on each request port. Each accepted operation is evaluated through the shared alu and captured in a single output register. That register drains through a valid/ready response port tagged with the requester id. Per-requester grant counters are exposed for performance and fairness checks.

Parameters:
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with req0 always winning.
CNT_W, 16, width of each grant counter; counters saturate at all-ones.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  32  operand A
req0_b  input  32  operand B
req0_op  input  3  ALUOp
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  32  operand A
req1_b  input  32  operand B
req1_op  input  3  ALUOp
rsp_valid  output  1  result register holds a result
rsp_ready  input  1  consumer accepts the result
rsp_id  output  1  requester that owns the result
rsp_result  output  32  alu result
rsp_err  output  1  op was unsupported (3'b111)
gnt_cnt0  output  CNT_W  accepted-op count, requester 0
gnt_cnt1  output  CNT_W  accepted-op count, requester 1

Behaviour:
- Reset (reset low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - gnt_cnt0=0, gnt_cnt1=0.
  - Priority pointer = req0.
  - Reset mid-operation discards any held result. No response is produced for an op accepted before reset.
- ALUOp encoding:
  - 000 ADD: A+B, modulo 2^32.
  - 001 SUB: A-B, modulo 2^32.
  - 010 OR, 011 XOR, 100 NOR: bitwise.
  - 101 CLO: count of leading ones of A, range 0..32.
  - 110 CLZ: count of leading zeros of A, range 0..32.
  - 111: result 0 and rsp_err=1.
  - Operand B is ignored for CLO and CLZ.
- Slot free condition: free = !rsp_valid || rsp_ready. This allows full throughput of one op per cycle.
- Grant (combinational):
  - Only one valid requester: that requester wins.
  - Both valid: the pointer side wins when RR_EN=1; req0 wins when RR_EN=0.
  - reqN_ready = free && winner==N. At most one ready is high in any cycle.
  - A ready is never asserted without the matching valid.
- Accept at a clock edge when reqN_valid && reqN_ready:
  - rsp_result, rsp_err and rsp_id are loaded from the alu output for the winner's operands.
  - rsp_valid=1 on the next cycle, giving a latency of 1 cycle from accept to rsp_valid.
  - The pointer moves to the non-winner.
  - gnt_cntN increments, saturating at all-ones.
- Drain:
  - rsp_valid && rsp_ready with no new accept clears rsp_valid.
  - A simultaneous drain and accept loads the new result, and rsp_valid stays 1.
- Backpressure: while rsp_valid && !rsp_ready, both readies are 0. The rsp_* outputs stay stable and the pointer does not move.
- The pointer does not move when no op is accepted. An idle requester therefore does not lose its turn.
- Requesters keep their operands stable while valid and not ready. A requester may drop valid before it is accepted; no state changes in that case.
- Starvation bound with RR_EN=1: a continuously valid requester is accepted within 2 free cycles.

Decomposition:
- Shared package holds the ALUOp constants: ADD, SUB, OR, XOR, NOR, CLO, CLZ, and ILLEGAL=3'b111.
- Shared package also holds the CLO/CLZ all-bits result constant, 32'h20.
- One sub-module: the existing alu (A, B, ALUOp, outcome), instantiated once. Its inputs are driven by the winner mux.
- The arbiter contains the grant logic, pointer, output register and counters. No other sub-modules.

Test Plan:
- Reset, then req0 ADD a=5 b=3 with rsp_ready=1 -> req0_ready=1 on cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, gnt_cnt0=1.
- Both valid from reset, streaming, with req0 SUB 10-3 and req1 XOR 0xF0F0_0000^0x0FF0_0000 -> accepts alternate 0,1,0,1. Results are 7 and 0xFF00_0000, and gnt_cnt0 equals gnt_cnt1 after 8 cycles.
- RR_EN=0, both valid for 4 cycles -> only req0 is accepted and gnt_cnt1 stays 0.
- req1 CLZ a=0x0000_FFFF -> result 16; CLO a=0xFFFF_FFFF -> 32; CLZ a=0 -> 32; CLO a=0x7FFF_FFFF -> 0.
- Hold rsp_ready=0 for 3 cycles with both requesters valid -> both readies are 0 and rsp_* are stable. When rsp_ready rises, drain and the next accept happen in the same cycle.
- req0 op=3'b111 -> rsp_result=0, rsp_err=1. Then assert reset while rsp_valid=1 -> all outputs return to 0 immediately.
